mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (I) and the data/MEM-stage requester (D).
- Arbitrates per request and locks the grant until the handshake completes.
- Tracks outstanding requests in an in-order tag FIFO and routes each response back to its originator.
- Sits between pipeline_fetch/pipeline_mem and the external memory interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, >=2).
- STARVE_LIMIT, 3, consecutive I-losing cycles before I is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- i_req_valid  in  1  fetch request valid
- i_req_addr  in  ADDR_W  fetch address
- i_req_ready  out  1  fetch request accepted this cycle
- d_req_valid  in  1  data request valid
- d_req_addr  in  ADDR_W  data address
- d_req_we  in  1  data write enable
- d_req_wdata  in  DATA_W  write data
- d_req_wstrb  in  DATA_W/8  byte strobes
- d_req_ready  out  1  data request accepted this cycle
- m_req_valid  out  1  memory request valid
- m_req_addr  out  ADDR_W  memory address
- m_req_we  out  1  memory write enable (0 for I)
- m_req_wdata  out  DATA_W  write data (0 for I)
- m_req_wstrb  out  DATA_W/8  strobes (0 for I)
- m_req_ready  in  1  memory accepts request
- m_resp_valid  in  1  memory response (one per accepted request, in order, writes included)
- m_resp_rdata  in  DATA_W  response data
- m_resp_err  in  1  response bus error
- i_resp_valid  out  1  fetch response valid
- i_resp_rdata  out  DATA_W  fetch data
- i_resp_err  out  1  fetch error
- d_resp_valid  out  1  data response valid
- d_resp_rdata  out  DATA_W  data read data
- d_resp_err  out  1  data error
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  in-flight request count
- spurious_resp  out  1  sticky: response arrived with empty tag FIFO

Behaviour:
- Reset:
  - State IDLE; FIFO empty; starve counter 0; spurious_resp 0.
  - All valid/ready outputs 0; data outputs 0.
  - Responses arriving during reset are dropped.
- States:
  - IDLE: no grant held.
    - Tag FIFO full: no grant.
    - Only one requester valid: grant it.
    - Both valid: D wins unless starve counter == STARVE_LIMIT, in which case I wins.
    - m_req_valid asserts combinationally from the winner this cycle.
    - m_req_ready same cycle: accept and stay IDLE.
    - Otherwise register the winner: D -> HOLD_D, I -> HOLD_I.
  - HOLD_I / HOLD_D:
    - m_req_* driven from the locked source; no re-arbitration.
    - Requester must keep valid and payload stable; the arbiter does not check this.
    - m_req_ready -> accept, go to IDLE.
- Accept: req_ready to the source = m_req_valid & m_req_ready & source selected. The loser's ready is 0.
- Tag FIFO:
  - Push the source tag (0 = I, 1 = D) on accept.
  - Pop on m_resp_valid when non-empty.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - No push when full, even if a pop occurs the same cycle.
  - outstanding reflects the registered count.
- Response routing:
  - Combinational, zero latency from m_resp_valid.
  - Exactly one of i_resp_valid/d_resp_valid asserts, selected by the FIFO head.
  - Non-selected rdata/err = 0.
- Empty-FIFO response: dropped, no resp_valid; spurious_resp sets and stays set until rst.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each IDLE cycle where I is valid and D is granted.
  - Clears when I is accepted.
  - Holds otherwise, including HOLD states and full-FIFO stalls.
- Reset mid-operation: locked grant released, FIFO cleared, outstanding = 0. The next response counts as spurious.

Test Plan:
- Single I read at addr 0x100, m_req_ready=1, response 2 cycles later with rdata 0xDEADBEEF -> i_req_ready pulses once, outstanding 1 then 0, i_resp_valid with 0xDEADBEEF, d_resp_valid stays 0.
- I and D valid continuously, memory always ready, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; tag FIFO routes each response to the matching requester.
- D write 0x200, wdata 0x12345678, wstrb 4'b0011, m_req_ready low for 3 cycles while I is valid -> stays HOLD_D with m_req_addr=0x200 throughout, then accepts D; I is not granted during the hold.
- Issue 4 I reads with no responses (MAX_OUTSTANDING=4) -> outstanding=4, 5th request sees i_req_ready=0 and m_req_valid=0. One response arrives -> 5th accepted next cycle, not in the pop cycle.
- m_resp_valid with empty FIFO -> no resp_valid, spurious_resp=1 and stays 1; after rst, spurious_resp=0.
- D read with response m_resp_err=1 -> d_resp_err=1 and i_resp_err=0. Assert rst while 2 requests are outstanding -> outstanding=0, and the following response is flagged spurious.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data (D) requesters.
// Grants are locked until the handshake completes; responses are routed back by an in-order tag FIFO.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_req_valid,
  input  logic [ADDR_W-1:0]                  i_req_addr,
  output logic                               i_req_ready,
  input  logic                               d_req_valid,
  input  logic [ADDR_W-1:0]                  d_req_addr,
  input  logic                               d_req_we,
  input  logic [DATA_W-1:0]                  d_req_wdata,
  input  logic [DATA_W/8-1:0]                d_req_wstrb,
  output logic                               d_req_ready,
  output logic                               m_req_valid,
  output logic [ADDR_W-1:0]                  m_req_addr,
  output logic                               m_req_we,
  output logic [DATA_W-1:0]                  m_req_wdata,
  output logic [DATA_W/8-1:0]                m_req_wstrb,
  input  logic                               m_req_ready,
  input  logic                               m_resp_valid,
  input  logic [DATA_W-1:0]                  m_resp_rdata,
  input  logic                               m_resp_err,
  output logic                               i_resp_valid,
  output logic [DATA_W-1:0]                  i_resp_rdata,
  output logic                               i_resp_err,
  output logic                               d_resp_valid,
  output logic [DATA_W-1:0]                  d_resp_rdata,
  output logic                               d_resp_err,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               spurious_resp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [STV_W-1:0]           r_starve;
  logic [STV_W-1:0]           w_starve_next;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [CNT_W-1:0]           r_count;
  logic [MAX_OUTSTANDING-1:0] r_tag;
  logic                       r_spurious;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_grant;
  logic                       w_sel_d;
  logic                       w_req_on;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_head_d;
  logic [MAX_OUTSTANDING-1:0] w_slot_we;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant selection: IDLE arbitrates fresh, HOLD states replay the locked source.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_sel_d      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_full) begin
          if (d_req_valid && i_req_valid) begin
            w_grant = 1'b1;
            w_sel_d = (r_starve != STV_MAX);
          end else if (d_req_valid) begin
            w_grant = 1'b1;
            w_sel_d = 1'b1;
          end else if (i_req_valid) begin
            w_grant = 1'b1;
            w_sel_d = 1'b0;
          end
        end
        if (w_grant && !m_req_ready) begin
          w_state_next = w_sel_d ? ST_HOLD_D : ST_HOLD_I;
        end
      end
      ST_HOLD_I: begin
        w_grant = 1'b1;
        w_sel_d = 1'b0;
        if (m_req_ready) w_state_next = ST_IDLE;
      end
      ST_HOLD_D: begin
        w_grant = 1'b1;
        w_sel_d = 1'b1;
        if (m_req_ready) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_req_on = w_grant & ~rst;
  assign w_accept = w_req_on & m_req_ready;
  assign w_push   = w_accept & ~w_full;
  assign w_pop    = m_resp_valid & ~w_empty & ~rst;

  // Starve counter only moves on IDLE-cycle losses by I; an I accept clears it.
  always_comb begin
    w_starve_next = r_starve;
    if (r_state == ST_IDLE && w_grant && w_sel_d && i_req_valid && r_starve != STV_MAX) begin
      w_starve_next = r_starve + 1'b1;
    end
    if (w_accept && !w_sel_d) begin
      w_starve_next = '0;
    end
  end

  assign m_req_valid = w_req_on;
  assign m_req_addr  = !w_req_on ? '0 : (w_sel_d ? d_req_addr : i_req_addr);
  assign m_req_we    = w_req_on & w_sel_d & d_req_we;
  assign m_req_wdata = (w_req_on && w_sel_d) ? d_req_wdata : '0;
  assign m_req_wstrb = (w_req_on && w_sel_d) ? d_req_wstrb : {STRB_W{1'b0}};
  assign i_req_ready = w_accept & ~w_sel_d;
  assign d_req_ready = w_accept & w_sel_d;

  // Tag storage is tiny and read combinationally at the head, so it lives in flops.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot
      assign w_slot_we[gi] = w_push && (r_wr_ptr == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else begin
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
        if (w_slot_we[k]) r_tag[k] <= w_sel_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_spurious <= 1'b0;
    end else begin
      r_starve <= w_starve_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_resp_valid && w_empty) r_spurious <= 1'b1;
    end
  end

  assign w_head_d     = r_tag[r_rd_ptr];
  assign i_resp_valid = w_pop & ~w_head_d;
  assign i_resp_rdata = i_resp_valid ? m_resp_rdata : '0;
  assign i_resp_err   = i_resp_valid & m_resp_err;
  assign d_resp_valid = w_pop & w_head_d;
  assign d_resp_rdata = d_resp_valid ? m_resp_rdata : '0;
  assign d_resp_err   = d_resp_valid & m_resp_err;

  assign outstanding   = r_count;
  assign spurious_resp = r_spurious;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, grant lock, FIFO full stall,
// response routing, spurious detection and mid-flight reset.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          d_req_valid;
  logic [AW-1:0] d_req_addr;
  logic          d_req_we;
  logic [DW-1:0] d_req_wdata;
  logic [SW-1:0] d_req_wstrb;
  logic          d_req_ready;
  logic          m_req_valid;
  logic [AW-1:0] m_req_addr;
  logic          m_req_we;
  logic [DW-1:0] m_req_wdata;
  logic [SW-1:0] m_req_wstrb;
  logic          m_req_ready;
  logic          m_resp_valid;
  logic [DW-1:0] m_resp_rdata;
  logic          m_resp_err;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_rdata;
  logic          i_resp_err;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_rdata;
  logic          d_resp_err;
  logic [CW-1:0] outstanding;
  logic          spurious_resp;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_ready(m_req_ready),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .outstanding(outstanding), .spurious_resp(spurious_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit exp_d [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_we = 1'b0;
    d_req_wdata = 32'h0; d_req_wstrb = 4'h0;
    m_req_ready = 1'b1; m_resp_valid = 1'b1; m_resp_rdata = 32'h0; m_resp_err = 1'b0;

    // Reset: everything quiet even with live inputs
    tick();
    tick();
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_i_req_ready", i_req_ready, 0);
    chk("rst_i_resp_valid", i_resp_valid, 0);
    chk("rst_m_req_addr", m_req_addr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_spurious", spurious_resp, 0);
    rst = 1'b0; i_req_valid = 1'b0; m_resp_valid = 1'b0;
    tick();
    chk("rst_resp_dropped", spurious_resp, 0);
    $display("txn reset done");

    // Single I read at 0x100
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    #1;
    chk("i1_m_req_valid", m_req_valid, 1);
    chk("i1_m_req_addr", m_req_addr, 32'h100);
    chk("i1_m_req_we", m_req_we, 0);
    chk("i1_i_req_ready", i_req_ready, 1);
    chk("i1_d_req_ready", d_req_ready, 0);
    tick();
    i_req_valid = 1'b0;
    #1;
    chk("i1_outstanding1", outstanding, 1);
    chk("i1_ready_once", i_req_ready, 0);
    tick();
    m_resp_valid = 1'b1; m_resp_rdata = 32'hDEADBEEF;
    #1;
    chk("i1_resp_valid", i_resp_valid, 1);
    chk("i1_resp_rdata", i_resp_rdata, 32'hDEADBEEF);
    chk("i1_d_resp_valid", d_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0;
    #1;
    chk("i1_outstanding0", outstanding, 0);
    $display("txn single I read 0x100 done");

    // Both valid, memory always ready: D,D,D,I,D,D,D,I; response one cycle behind
    i_req_valid = 1'b1; i_req_addr = 32'h1000;
    d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_we = 1'b0;
    m_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_resp_valid = (k > 0);
      m_resp_rdata = 32'hA000_0000 + k;
      #1;
      chk("rr_d_ready", d_req_ready, exp_d[k]);
      chk("rr_i_ready", i_req_ready, !exp_d[k]);
      chk("rr_addr", m_req_addr, exp_d[k] ? 32'h2000 : 32'h1000);
      if (k > 0) begin
        chk("rr_d_resp", d_resp_valid, exp_d[k-1]);
        chk("rr_i_resp", i_resp_valid, !exp_d[k-1]);
      end
      $display("txn rr step=%0d grant=%s", k, exp_d[k] ? "D" : "I");
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    m_resp_valid = 1'b1; m_resp_rdata = 32'hA000_0008;
    #1;
    chk("rr_last_i_resp", i_resp_valid, 1);
    chk("rr_last_d_resp", d_resp_valid, 0);
    chk("rr_last_rdata", i_resp_rdata, 32'hA000_0008);
    tick();
    m_resp_valid = 1'b0;
    #1;
    chk("rr_drained", outstanding, 0);

    // D write held for 3 cycles while I waits
    i_req_valid = 1'b1; i_req_addr = 32'h1004;
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_we = 1'b1;
    d_req_wdata = 32'h12345678; d_req_wstrb = 4'b0011;
    m_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_valid", m_req_valid, 1);
      chk("hold_addr", m_req_addr, 32'h200);
      chk("hold_we", m_req_we, 1);
      chk("hold_wdata", m_req_wdata, 32'h12345678);
      chk("hold_wstrb", m_req_wstrb, 4'b0011);
      chk("hold_d_ready", d_req_ready, 0);
      chk("hold_i_ready", i_req_ready, 0);
      tick();
    end
    m_req_ready = 1'b1;
    #1;
    chk("hold_d_accept", d_req_ready, 1);
    chk("hold_i_not", i_req_ready, 0);
    chk("hold_addr_acc", m_req_addr, 32'h200);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    m_resp_valid = 1'b1; m_resp_rdata = 32'h0;
    #1;
    chk("wr_outstanding", outstanding, 1);
    chk("wr_d_resp", d_resp_valid, 1);
    chk("wr_i_resp", i_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0; d_req_we = 1'b0; d_req_wdata = 32'h0; d_req_wstrb = 4'h0;
    #1;
    chk("wr_drained", outstanding, 0);
    $display("txn D write 0x200 held 3 cycles done");

    // Fill the tag FIFO with 4 I reads, then stall the 5th
    i_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_req_addr = 32'h300 + 32'(4 * k);
      #1;
      chk("fill_i_ready", i_req_ready, 1);
      chk("fill_addr", m_req_addr, 32'h300 + 32'(4 * k));
      tick();
    end
    i_req_addr = 32'h310;
    #1;
    chk("full_outstanding", outstanding, 4);
    chk("full_i_ready", i_req_ready, 0);
    chk("full_m_valid", m_req_valid, 0);
    tick();
    m_resp_valid = 1'b1; m_resp_rdata = 32'h11;
    #1;
    chk("popcyc_i_ready", i_req_ready, 0);
    chk("popcyc_m_valid", m_req_valid, 0);
    chk("popcyc_resp", i_resp_valid, 1);
    chk("popcyc_outstanding", outstanding, 4);
    tick();
    m_resp_valid = 1'b0;
    #1;
    chk("after_pop_outstanding", outstanding, 3);
    chk("fifth_i_ready", i_req_ready, 1);
    chk("fifth_addr", m_req_addr, 32'h310);
    tick();
    i_req_valid = 1'b0;
    #1;
    chk("refill_outstanding", outstanding, 4);
    for (int k = 0; k < 4; k++) begin
      m_resp_valid = 1'b1; m_resp_rdata = 32'h20 + 32'(k);
      #1;
      chk("drain_i_resp", i_resp_valid, 1);
      tick();
    end
    m_resp_valid = 1'b0;
    #1;
    chk("drain_outstanding", outstanding, 0);
    $display("txn FIFO full stall done");

    // Response with empty FIFO
    m_resp_valid = 1'b1; m_resp_rdata = 32'h55;
    #1;
    chk("spur_i_resp", i_resp_valid, 0);
    chk("spur_d_resp", d_resp_valid, 0);
    chk("spur_i_rdata", i_resp_rdata, 0);
    tick();
    m_resp_valid = 1'b0;
    #1;
    chk("spur_set", spurious_resp, 1);
    tick();
    tick();
    chk("spur_sticky", spurious_resp, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("spur_cleared", spurious_resp, 0);
    $display("txn spurious response done");

    // D read with bus error
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_we = 1'b0; m_req_ready = 1'b1;
    #1;
    chk("err_d_ready", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    m_resp_valid = 1'b1; m_resp_err = 1'b1; m_resp_rdata = 32'hBAD;
    #1;
    chk("err_d_resp", d_resp_valid, 1);
    chk("err_d_err", d_resp_err, 1);
    chk("err_d_rdata", d_resp_rdata, 32'hBAD);
    chk("err_i_err", i_resp_err, 0);
    chk("err_i_resp", i_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0; m_resp_err = 1'b0;
    $display("txn D read error done");

    // Reset with two requests outstanding
    d_req_valid = 1'b1; d_req_addr = 32'h404;
    #1;
    chk("mid_acc1", d_req_ready, 1);
    tick();
    d_req_addr = 32'h408;
    #1;
    chk("mid_acc2", d_req_ready, 1);
    tick();
    d_req_valid = 1'b0;
    #1;
    chk("mid_outstanding2", outstanding, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_outstanding", outstanding, 0);
    rst = 1'b0;
    m_resp_valid = 1'b1; m_resp_rdata = 32'h77;
    #1;
    chk("mid_no_d_resp", d_resp_valid, 0);
    chk("mid_no_i_resp", i_resp_valid, 0);
    tick();
    m_resp_valid = 1'b0;
    #1;
    chk("mid_spurious", spurious_resp, 1);
    $display("txn reset mid-flight done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
